// File: rtl/bcd_counter_mux_display.sv
// bcd_counter_mux_display
//   NUM_DIGITS-digit BCD up/down counter stepped by an internal prescaler tick,
//   with a time-multiplexed, active-low common-anode 7-segment driver.
//   Optional feature: define LZ_BLANK_EN for leading-zero blanking on the display.
module bcd_counter_mux_display #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10_000_000,
    parameter int SCAN_BITS  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]         prescale_q, prescale_d;
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d, digits_step;
    logic                    chain_out;
    logic                    wrap_q, wrap_d;
    logic [SCAN_BITS-1:0]    scan_cnt_q;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              sel_digit;
    logic                    sel_blank;

    // gfedcba, active-low; anything outside 0..9 shows a dash
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // The step only fires while running, so a paused prescaler never ticks
    assign tick = enable && (prescale_q == PS_LAST);

    // Prescaler next state: clear wins, tick restarts, pause holds
    always_comb begin
        prescale_d = prescale_q;
        if (clear || tick) begin
            prescale_d = '0;
        end else if (enable) begin
            prescale_d = prescale_q + PS_W'(1);
        end
    end

    // Ripple carry/borrow through all digits; chain_out set means full rollover
    always_comb begin
        logic       c;
        logic [3:0] cur;
        c           = 1'b1;
        digits_step = digits_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur = digits_q[4*i +: 4];
            if (c) begin
                if (up_down) begin
                    if (cur >= 4'd9) begin
                        digits_step[4*i +: 4] = 4'd0;
                    end else begin
                        digits_step[4*i +: 4] = cur + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (cur == 4'd0) begin
                        digits_step[4*i +: 4] = 4'd9;
                    end else begin
                        digits_step[4*i +: 4] = cur - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        chain_out = c;
    end

    // Count next state: clear takes priority over a coincident tick
    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (clear) begin
            digits_d = '0;
        end else if (tick) begin
            digits_d = digits_step;
            wrap_d   = chain_out;
        end
    end

    // Scan index advances on the last cycle of each digit's display slot
    always_comb begin
        scan_idx_d = scan_idx_q;
        if (&scan_cnt_q) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    // Counter, prescaler and scan state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
            digits_q   <= '0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            prescale_q <= prescale_d;
            digits_q   <= digits_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_q + SCAN_BITS'(1);
            scan_idx_q <= scan_idx_d;
        end
    end

`ifdef LZ_BLANK_EN
    // A digit above 0 is blank when it and everything above it are zero
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (digits_q[4*i +: 4] == 4'd0);
            blank[i]   = (i != 0) && zero_above;
        end
    end
`else
    // Every digit is always decoded, zeros included
    always_comb begin
        blank = '0;
    end
`endif

    // Pick the digit currently being scanned and its blanking flag
    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                sel_digit = digits_q[4*i +: 4];
                sel_blank = blank[i];
            end
        end
    end

    // One anode low at a time, following the scan index
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an[gi] = (scan_idx_q != IDX_W'(gi));
        end
    endgenerate

    assign seg  = sel_blank ? 7'h7F : decode(sel_digit);
    assign dp   = 1'b1;
    assign bcd  = digits_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_mux_display.sv
// Directed bench for bcd_counter_mux_display with 3 digits, a divide-by-4
// prescaler and a 4-clock scan slot per digit.
module tb_bcd_counter_mux_display;

    localparam int ND = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          up_down;
    logic          clear;
    logic [4*ND-1:0] bcd;
    logic          wrap;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    logic wrap_prev = 1'b0;

    localparam logic [6:0] DEC [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
`ifdef LZ_BLANK_EN
    localparam logic [6:0] LEAD_ZERO_SEG = 7'h7F;
`else
    localparam logic [6:0] LEAD_ZERO_SEG = 7'b1000000;
`endif

    bcd_counter_mux_display #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (4),
        .SCAN_BITS (2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .up_down(up_down),
        .clear  (clear),
        .bcd    (bcd),
        .wrap   (wrap),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 clock = ~clock;

    // Clock edges since reset release: the scan position model
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int exp_idx();
        return (cyc / 4) % ND;
    endfunction

    function automatic logic [ND-1:0] exp_an();
        logic [ND-1:0] one;
        one = 1;
        return ~(one << exp_idx());
    endfunction

    // Every-cycle properties: anode scan model, one-hot-low, digit range, wrap width
    always @(negedge clock) begin
        if (mon_en) begin
            check_value("an_scan", an, exp_an());
            check_value("an_onehot", $countones(~an), 1);
            for (int i = 0; i < ND; i++) begin
                check_value("digit_range", bcd[4*i +: 4] <= 4'd9, 1);
            end
            check_value("wrap_1cyc", wrap_prev & wrap, 0);
            wrap_prev = wrap;
        end
    end

    // Check the segment pattern for the scanned digit over n clocks
    task automatic check_scan(input string tag, input int n, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2,
                              input logic [4*ND-1:0] held);
        logic [6:0] exp_seg;
        for (int k = 0; k < n; k++) begin
            step_clk(1);
            case (exp_idx())
                0:       exp_seg = s0;
                1:       exp_seg = s1;
                default: exp_seg = s2;
            endcase
            check_value({tag, "_bcd"}, bcd, held);
            check_value({tag, "_an"}, an, exp_an());
            check_value({tag, "_seg"}, seg, exp_seg);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0;
        #1 reset = 1'b1;
        step_clk(1);

        // 1: reset state
        mon_en = 1'b1;
        check_value("rst_bcd", bcd, 12'h000);
        check_value("rst_wrap", wrap, 0);
        check_value("rst_an", an, 3'b110);
        check_value("rst_seg", seg, 7'b1000000);
        check_value("rst_dp", dp, 1);
        $display("step1: reset bcd=%h an=%b seg=%b", bcd, an, seg);
        reset = 1'b0;

        // 2: count up, carry into digit 1
        enable = 1'b1; up_down = 1'b1;
        step_clk(3);
        check_value("up_pre_tick", bcd, 12'h000);
        step_clk(1);
        check_value("up_first", bcd, 12'h001);
        step_clk(36);
        check_value("up_40", bcd, 12'h010);
        $display("step2: 40 clocks up bcd=%h", bcd);

        // 3: roll over upward, then downward
        step_clk(989 * 4);
        check_value("up_999", bcd, 12'h999);
        check_value("up_999_wrap", wrap, 0);
        step_clk(4);
        check_value("wrap_up_bcd", bcd, 12'h000);
        check_value("wrap_up", wrap, 1);
        step_clk(1);
        check_value("wrap_up_end", wrap, 0);
        up_down = 1'b0;
        step_clk(3);
        check_value("wrap_dn_bcd", bcd, 12'h999);
        check_value("wrap_dn", wrap, 1);
        step_clk(1);
        check_value("wrap_dn_end", wrap, 0);
        $display("step3: up and down rollover bcd=%h", bcd);

        // 4: reach 123 from a clear, then pause and watch the scan
        clear = 1'b1;
        step_clk(1);
        check_value("clr_bcd", bcd, 12'h000);
        clear = 1'b0; up_down = 1'b1;
        step_clk(123 * 4);
        check_value("at_123", bcd, 12'h123);
        enable = 1'b0;
        check_scan("pause", 20, DEC[3], DEC[2], DEC[1], 12'h123);
        $display("step4: paused at bcd=%h", bcd);

        // 5: clear coincident with a tick at 456
        enable = 1'b1;
        step_clk(333 * 4);
        check_value("at_456", bcd, 12'h456);
        step_clk(3);
        check_value("tick_cycle_456", bcd, 12'h456);
        clear = 1'b1;
        step_clk(1);
        check_value("clr_tick_bcd", bcd, 12'h000);
        check_value("clr_tick_wrap", wrap, 0);
        clear = 1'b0;
        step_clk(3);
        check_value("clr_restart_hold", bcd, 12'h000);
        step_clk(1);
        check_value("clr_restart_step", bcd, 12'h001);
        $display("step5: clear over tick bcd=%h", bcd);

        // 6: leading zeros at 007
        step_clk(24);
        check_value("at_007", bcd, 12'h007);
        enable = 1'b0;
        check_scan("lz", 12, DEC[7], LEAD_ZERO_SEG, LEAD_ZERO_SEG, 12'h007);
        $display("step6: bcd=%h leading digits seg=%b", bcd, LEAD_ZERO_SEG);

        // 7: asynchronous reset mid-count and mid-scan
        enable = 1'b1;
        step_clk(6);
        #2 reset = 1'b1;
        #1;
        check_value("async_bcd", bcd, 12'h000);
        check_value("async_an", an, 3'b110);
        check_value("async_seg", seg, 7'b1000000);
        step_clk(1);
        reset = 1'b0;
        step_clk(4);
        check_value("after_rst_step", bcd, 12'h001);
        $display("step7: async reset then one step bcd=%h", bcd);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
